// File: rtl/pc_ras.sv
// Fetch-stage program counter with integrated return-address stack and sticky fault flags.
// Latency: 1 cycle from sampled command strobe to new pc/depth (all outputs registered or derived from registers).
// Backpressure: stall freezes pc and stack (strobes dropped, not queued); err_clr still acts during stall.
module pc_ras #(
    parameter int                 WIDTH     = 16,
    parameter int                 DEPTH     = 8,
    parameter logic [WIDTH-1:0]   RESET_VEC = '0,
    parameter logic [WIDTH-1:0]   INC_STEP  = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        stall,
    input  logic                        inc,
    input  logic                        add,
    input  logic                        sub,
    input  logic                        jmp,
    input  logic                        call,
    input  logic                        ret,
    input  logic                        err_clr,
    input  logic [WIDTH-1:0]            offset,
    input  logic [WIDTH-1:0]            target,
    output logic [WIDTH-1:0]            pc,
    output logic [$clog2(DEPTH+1)-1:0]  depth,
    output logic                        full,
    output logic                        empty,
    output logic                        overflow,
    output logic                        underflow
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [DW-1:0] DEPTH_V = DW'(DEPTH);
    localparam logic [DW-1:0] ONE_D   = DW'(1);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [DW-1:0]    depth_q, depth_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [WIDTH-1:0] stack_q [DEPTH];
    logic [WIDTH-1:0] stack_d [DEPTH];

    logic [AW-1:0]    push_idx;
    logic [AW-1:0]    pop_idx;
    logic             full_w;
    logic             empty_w;

    // push slot is the first free entry, pop slot the top of stack; both only used when in range
    assign push_idx = AW'(depth_q);
    assign pop_idx  = AW'(depth_q - ONE_D);
    assign full_w   = (depth_q == DEPTH_V);
    assign empty_w  = (depth_q == '0);

    // next-state: flag clear first so a fault in the same cycle wins, then one prioritised command
    always_comb begin
        pc_d    = pc_q;
        depth_d = depth_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        stack_d = stack_q;
        if (err_clr) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        if (!stall) begin
            if (ret) begin
                if (empty_w) begin
                    unf_d = 1'b1;
                end else begin
                    pc_d    = stack_q[pop_idx];
                    depth_d = depth_q - ONE_D;
                end
            end else if (call) begin
                if (full_w) begin
                    // suppressed entirely: no jump without a saved return address
                    ovf_d = 1'b1;
                end else begin
                    stack_d[push_idx] = pc_q + INC_STEP;
                    depth_d           = depth_q + ONE_D;
                    pc_d              = target;
                end
            end else if (jmp) begin
                pc_d = target;
            end else if (sub) begin
                pc_d = pc_q - offset;
            end else if (add) begin
                pc_d = pc_q + offset;
            end else if (inc) begin
                pc_d = pc_q + INC_STEP;
            end
        end
    end

    // control state with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_VEC;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // stack storage is not reset; entries above depth are never read
    always_ff @(posedge clk) begin
        stack_q <= stack_d;
    end

    assign pc        = pc_q;
    assign depth     = depth_q;
    assign full      = full_w;
    assign empty     = empty_w;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_pc_ras.sv
// Randomised and directed bench for pc_ras against a queue-based reference model.
// Latency: expected state for each issued command is compared one cycle later.
// Backpressure: stall/err_clr exercised as part of the command mix.
module tb_pc_ras;

    localparam int W = 16;
    localparam int D = 4;

    localparam bit [8:0] R   = 9'h100;
    localparam bit [8:0] ST  = 9'h080;
    localparam bit [8:0] INC = 9'h040;
    localparam bit [8:0] ADD = 9'h020;
    localparam bit [8:0] SUB = 9'h010;
    localparam bit [8:0] JMP = 9'h008;
    localparam bit [8:0] CAL = 9'h004;
    localparam bit [8:0] RET = 9'h002;
    localparam bit [8:0] CLR = 9'h001;

    typedef struct {
        logic [W-1:0] pc;
        int           depth;
        logic         full;
        logic         empty;
        logic         ovf;
        logic         unf;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset, stall, inc, add, sub, jmp, call, ret, err_clr;
    logic [W-1:0] offset, target;
    logic [W-1:0] pc;
    logic [2:0]   depth;
    logic         full, empty, overflow, underflow;

    int checks = 0;
    int errors = 0;

    exp_t         expq[$];
    logic [W-1:0] m_pc;
    logic [W-1:0] m_stack[$];
    logic         m_ovf, m_unf;
    exp_t         mon_e;

    pc_ras #(.WIDTH(W), .DEPTH(D), .RESET_VEC(16'h0000), .INC_STEP(16'h0001)) dut (
        .clk(clk), .reset(reset), .stall(stall), .inc(inc), .add(add), .sub(sub),
        .jmp(jmp), .call(call), .ret(ret), .err_clr(err_clr),
        .offset(offset), .target(target), .pc(pc), .depth(depth),
        .full(full), .empty(empty), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Reference: stack as a queue, one action chosen from the highest-priority strobe.
    task automatic model(input bit [8:0] m, input logic [W-1:0] off, input logic [W-1:0] tgt);
        bit set_o = 0, set_u = 0;
        exp_t e;
        if (m & R) begin
            m_pc = 16'h0000;
            m_stack.delete();
            m_ovf = 0;
            m_unf = 0;
        end else begin
            if (!(m & ST)) begin
                if (m & RET) begin
                    if (m_stack.size() == 0) set_u = 1;
                    else m_pc = m_stack.pop_back();
                end else if (m & CAL) begin
                    if (m_stack.size() == D) set_o = 1;
                    else begin
                        m_stack.push_back(m_pc + 16'd1);
                        m_pc = tgt;
                    end
                end else if (m & JMP) m_pc = tgt;
                else if (m & SUB) m_pc = m_pc - off;
                else if (m & ADD) m_pc = m_pc + off;
                else if (m & INC) m_pc = m_pc + 16'd1;
            end
            if (m & CLR) begin
                m_ovf = 0;
                m_unf = 0;
            end
            if (set_o) m_ovf = 1;
            if (set_u) m_unf = 1;
        end
        e.pc    = m_pc;
        e.depth = m_stack.size();
        e.full  = (m_stack.size() == D);
        e.empty = (m_stack.size() == 0);
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        expq.push_back(e);
    endtask

    // Drive one command for one cycle and record the expected result.
    task automatic issue(input bit [8:0] m, input logic [W-1:0] off, input logic [W-1:0] tgt);
        @(negedge clk);
        reset   = m[8];
        stall   = m[7];
        inc     = m[6];
        add     = m[5];
        sub     = m[4];
        jmp     = m[3];
        call    = m[2];
        ret     = m[1];
        err_clr = m[0];
        offset  = off;
        target  = tgt;
        model(m, off, tgt);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every cycle with an outstanding expectation, compare the registered outputs.
    always @(posedge clk) begin
        #1;
        if (expq.size() != 0) begin
            mon_e = expq.pop_front();
            chk("pc", int'(pc), int'(mon_e.pc));
            chk("depth", int'(depth), mon_e.depth);
            chk("full", int'(full), int'(mon_e.full));
            chk("empty", int'(empty), int'(mon_e.empty));
            chk("overflow", int'(overflow), int'(mon_e.ovf));
            chk("underflow", int'(underflow), int'(mon_e.unf));
        end
    end

    initial begin
        bit [8:0] m;
        {reset, stall, inc, add, sub, jmp, call, ret, err_clr} = '0;
        offset = '0;
        target = '0;
        m_pc = '0;
        m_ovf = 0;
        m_unf = 0;

        // basic arithmetic
        issue(R, 0, 0);
        issue(INC, 0, 0);
        issue(ADD, 16'h00A5, 0);
        issue(0, 0, 0);
        issue(INC, 0, 0);
        issue(SUB, 16'h0014, 0);
        // wrap-around
        issue(JMP, 0, 16'hFFFF);
        issue(INC, 0, 0);
        issue(SUB, 16'h0001, 0);
        issue(ADD, 16'h0002, 0);
        // nesting
        issue(JMP, 0, 16'h0010);
        issue(CAL, 0, 16'h0100);
        issue(CAL, 0, 16'h0200);
        issue(RET, 0, 0);
        issue(RET, 0, 0);
        // overflow then unwind
        issue(CAL, 0, 16'h1000);
        issue(CAL, 0, 16'h2000);
        issue(CAL, 0, 16'h3000);
        issue(CAL, 0, 16'h4000);
        issue(CAL, 0, 16'h5000);
        issue(CLR, 0, 0);
        for (int i = 0; i < 4; i++) issue(RET, 0, 0);
        // underflow and clear precedence
        issue(JMP, 0, 16'h0033);
        issue(RET, 0, 0);
        issue(RET | CLR, 0, 0);
        issue(CLR, 0, 0);
        // priority, stall, reset
        issue(JMP, 0, 16'h0040);
        issue(INC | ADD | CAL, 16'h0007, 16'h0500);
        issue(ST | INC, 0, 0);
        for (int i = 0; i < 4; i++) issue(CAL, 0, 16'h0600 + 16'(i));
        issue(ST | CLR | RET, 0, 0);
        issue(RET, 0, 0);
        issue(R | CAL, 0, 16'h0700);

        // randomised mix
        for (int n = 0; n < 3000; n++) begin
            m = '0;
            if ($urandom_range(63) == 0) m |= R;
            if ($urandom_range(7) == 0)  m |= ST;
            if ($urandom_range(3) == 0)  m |= INC;
            if ($urandom_range(3) == 0)  m |= ADD;
            if ($urandom_range(3) == 0)  m |= SUB;
            if ($urandom_range(5) == 0)  m |= JMP;
            if ($urandom_range(3) == 0)  m |= CAL;
            if ($urandom_range(3) == 0)  m |= RET;
            if ($urandom_range(7) == 0)  m |= CLR;
            issue(m, W'($urandom), W'($urandom));
        end

        @(negedge clk);
        {reset, stall, inc, add, sub, jmp, call, ret, err_clr} = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d expected=0 outstanding", expq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
